pkt_meta_merge: RTL

- Stage directly downstream of the parser/deparser pipeline.
- Buffers raw 134b packet words from the PHV-generation stage and waits for the per-packet 128b metadata result.
- Rewrites the Ethernet destination and source MAC of the head word from that metadata, then streams the packet out.
- Drops whole packets when buffering is exhausted, and keeps packet/metadata pairing aligned across drops.

---
 rtl/pkt_meta_merge.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_meta_merge.sv
// Buffers packet words until their metadata arrives, rewrites head-word MACs, drops whole packets when space runs out.
// Latency: first output word valid 2 cycles after the metadata write; there is no output backpressure (overflow is avoided by admission drops).

// Fall-through FIFO: rd_dat always shows the oldest entry; push and pop may share a cycle.
// Pushes into a full FIFO and pops from an empty one are ignored.
module pkt_meta_merge_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   cnt
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr  = wr_vld && (cnt != (AW+1)'(DEPTH));
    assign do_rd  = rd_rdy && (cnt != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
            else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module pkt_meta_merge #(
    parameter int PKT_AW        = 9,
    parameter int META_AW       = 4,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_pkt_valid,
    input  logic [133:0] i_pkt,
    input  logic         i_meta_valid,
    input  logic [127:0] i_meta,
    output logic         o_pkt_valid,
    output logic [133:0] o_pkt,
    output logic [31:0]  o_drop_cnt,
    output logic         o_meta_err
);
    localparam logic [1:0]         TAG_HEAD      = 2'b01;
    localparam logic [1:0]         TAG_TAIL      = 2'b10;
    localparam int                 PKT_DEPTH     = 1 << PKT_AW;
    localparam int                 META_DEPTH    = 1 << META_AW;
    localparam logic [PKT_AW:0]    PKT_ADMIT_MAX = (PKT_AW+1)'(PKT_DEPTH - MAX_PKT_WORDS);
    localparam logic [META_AW:0]   META_FULL     = (META_AW+1)'(META_DEPTH);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t state_r;
    state_t state_nx;

    logic          is_head;
    logic          is_tail;
    logic          in_pkt;
    logic          in_keep;
    logic          admit;

    logic          pkt_wr_vld;
    logic          pkt_rd_rdy;
    logic [133:0]  pkt_rd_dat;
    logic [PKT_AW:0] pkt_cnt;
    logic          pkt_avail;
    logic          pkt_is_tail;

    logic          tag_wr_vld;
    logic          tag_wr_dat;
    logic          tag_rd_rdy;
    logic          tag_rd_dat;
    logic [META_AW:0] tag_cnt;
    logic          tag_full;
    logic          tag_empty;

    logic          meta_wr_vld;
    logic          meta_rd_rdy;
    logic [96:0]   meta_rd_dat;
    logic [META_AW:0] meta_cnt;
    logic          meta_full;

    logic          out_vld;
    logic [133:0]  out_dat;

    assign is_head   = i_pkt_valid && (i_pkt[133:132] == TAG_HEAD);
    assign is_tail   = i_pkt_valid && (i_pkt[133:132] == TAG_TAIL);
    assign tag_full  = (tag_cnt == META_FULL);
    assign tag_empty = (tag_cnt == '0);
    assign meta_full = (meta_cnt == META_FULL);

    // Occupancy is the registered count, so a same-cycle output pop is not credited.
    assign admit = (pkt_cnt <= PKT_ADMIT_MAX) && !meta_full && !tag_full;

    assign pkt_wr_vld  = is_head ? admit : (i_pkt_valid && in_pkt && in_keep);
    assign tag_wr_vld  = is_head && !tag_full;
    assign tag_wr_dat  = admit;
    assign tag_rd_rdy  = i_meta_valid && !tag_empty;
    assign meta_wr_vld = tag_rd_rdy && tag_rd_dat;

    pkt_meta_merge_fifo #(.W(134), .AW(PKT_AW)) u_pkt_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .wr_vld   (pkt_wr_vld),
        .wr_dat   (i_pkt),
        .rd_rdy   (pkt_rd_rdy),
        .rd_dat   (pkt_rd_dat),
        .cnt      (pkt_cnt)
    );

    pkt_meta_merge_fifo #(.W(1), .AW(META_AW)) u_tag_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .wr_vld   (tag_wr_vld),
        .wr_dat   (tag_wr_dat),
        .rd_rdy   (tag_rd_rdy),
        .rd_dat   (tag_rd_dat),
        .cnt      (tag_cnt)
    );

    // Only dst/src MAC and the rewrite enable are kept; reserved bits are not stored.
    pkt_meta_merge_fifo #(.W(97), .AW(META_AW)) u_meta_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .wr_vld   (meta_wr_vld),
        .wr_dat   (i_meta[127:31]),
        .rd_rdy   (meta_rd_rdy),
        .rd_dat   (meta_rd_dat),
        .cnt      (meta_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_pkt     <= 1'b0;
            in_keep    <= 1'b0;
            o_drop_cnt <= '0;
            o_meta_err <= 1'b0;
        end else begin
            if (is_head) begin
                in_pkt  <= 1'b1;
                in_keep <= admit;
            end else if (is_tail) begin
                in_pkt  <= 1'b0;
            end
            if (is_head && !admit && (o_drop_cnt != 32'hFFFF_FFFF))
                o_drop_cnt <= o_drop_cnt + 32'd1;
            o_meta_err <= i_meta_valid && tag_empty;
        end
    end

    assign pkt_avail   = (pkt_cnt != '0);
    assign pkt_is_tail = (pkt_rd_dat[133:132] == TAG_TAIL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= IDLE;
        else          state_r <= state_nx;
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (meta_cnt != '0) state_nx = HEAD;
            HEAD:    if (pkt_avail) state_nx = BODY;
            BODY:    if (pkt_avail && pkt_is_tail) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pkt_rd_rdy  = 1'b0;
        meta_rd_rdy = 1'b0;
        out_vld     = 1'b0;
        out_dat     = pkt_rd_dat;
        case (state_r)
            HEAD: begin
                if (pkt_avail) begin
                    pkt_rd_rdy = 1'b1;
                    out_vld    = 1'b1;
                    if (meta_rd_dat[0]) out_dat[127:32] = meta_rd_dat[96:1];
                end
            end
            BODY: begin
                if (pkt_avail) begin
                    pkt_rd_rdy  = 1'b1;
                    out_vld     = 1'b1;
                    meta_rd_rdy = pkt_is_tail;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_valid <= 1'b0;
            o_pkt       <= '0;
        end else begin
            o_pkt_valid <= out_vld;
            if (out_vld) o_pkt <= out_dat;
        end
    end
endmodule
